// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: master issues divisions, slave is the divider.
interface seq_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) ();
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per RUN cycle, MSB first.
// SEQ_DIVIDER_DIV_ZERO_DETECT_EN: when defined, a zero divisor skips RUN and flags div_by_zero.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one restoring step per cycle, counter counts down to terminal count
// DONE  | one-cycle done pulse, results updated; start here chains the next division
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_if.slave   div_io
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
  logic                  dbz_q, dbz_d;
`endif

  logic [DIVISOR_W:0]    shifted;
  logic                  fits;
  logic [DIVISOR_W-1:0]  prem_step;
  logic [DIVIDEND_W-1:0] dvd_step;
  logic                  accept;

  // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom.
  // After a subtraction the partial remainder is below the divisor, so its low bits suffice.
  assign shifted   = {prem_q, dvd_q[DIVIDEND_W-1]};
  assign fits      = shifted >= {1'b0, dsr_q};
  assign prem_step = fits ? (shifted[DIVISOR_W-1:0] - dsr_q) : shifted[DIVISOR_W-1:0];
  assign dvd_step  = {dvd_q[DIVIDEND_W-2:0], fits};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    accept  = 1'b0;

    case (state_q)
      S_IDLE: accept = div_io.start;
      S_RUN: begin
        cnt_d  = cnt_q - CNT_W'(1);
        dvd_d  = dvd_step;
        prem_d = prem_step;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          quo_d   = dvd_step;
          rem_d   = prem_step;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      S_DONE: begin
        accept  = div_io.start;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_RUN;
      cnt_d   = CNT_W'(DIVIDEND_W);
      dvd_d   = div_io.dividend;
      dsr_d   = div_io.divisor;
      prem_d  = '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
      if (div_io.divisor == '0) begin
        state_d = S_DONE;
        cnt_d   = '0;
        quo_d   = '1;
        rem_d   = '0;
        dbz_d   = 1'b1;
      end
`endif
    end
  end

  assign div_io.quotient  = quo_q;
  assign div_io.remainder = rem_q;
  assign div_io.busy      = (state_q == S_RUN);
  assign div_io.done      = (state_q == S_DONE);
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
  assign div_io.div_by_zero = (state_q == S_DONE) && dbz_q;
`else
  assign div_io.div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results, negedge monitor pops and compares.
module tb_seq_divider;
  localparam int DW = 8;
  localparam int SW = 4;

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dz;
    int            done_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   free_edge = 0;
  exp_t sb[$];
  logic [DW-1:0] hold_q = '0;
  logic [SW-1:0] hold_r = '0;

  seq_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) div_if ();
  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_io (div_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_quotient"},  int'(div_if.quotient), 0);
    chk({tag, "_remainder"}, int'(div_if.remainder), 0);
    chk({tag, "_busy"},      int'(div_if.busy), 0);
    chk({tag, "_done"},      int'(div_if.done), 0);
    chk({tag, "_dbz"},       int'(div_if.div_by_zero), 0);
  endtask

  // Reference: plain integer division, with the zero-divisor conventions of each build.
  task automatic launch(input logic [DW-1:0] a, input logic [SW-1:0] b, output int e);
    exp_t x;
    e = edge_n + 1;
    if (b == '0) begin
      x.q = '1;
`ifdef SEQ_DIVIDER_DIV_ZERO_DETECT_EN
      x.r = '0;
      x.dz = 1'b1;
      x.done_edge = e;
`else
      x.r = a[SW-1:0];
      x.dz = 1'b0;
      x.done_edge = e + DW;
`endif
    end else begin
      x.q = DW'(int'(a) / int'(b));
      x.r = SW'(int'(a) % int'(b));
      x.dz = 1'b0;
      x.done_edge = e + DW;
    end
    free_edge = x.done_edge + 1;
    sb.push_back(x);
    div_if.start    = 1'b1;
    div_if.dividend = a;
    div_if.divisor  = b;
    step();
    div_if.start    = 1'b0;
    div_if.dividend = DW'($urandom);
    div_if.divisor  = SW'($urandom);
  endtask

  task automatic wait_free(input int gap);
    while (edge_n + 1 < free_edge + gap) step();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_q = '0;
      hold_r = '0;
    end else begin
      chk("busy_and_done", int'(div_if.busy && div_if.done), 0);
      if (div_if.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("quotient",     int'(div_if.quotient), int'(x.q));
          chk("remainder",    int'(div_if.remainder), int'(x.r));
          chk("div_by_zero",  int'(div_if.div_by_zero), int'(x.dz));
          chk("done_latency", edge_n, x.done_edge);
          hold_q = x.q;
          hold_r = x.r;
        end
      end else begin
        chk("quotient_hold",  int'(div_if.quotient), int'(hold_q));
        chk("remainder_hold", int'(div_if.remainder), int'(hold_r));
        chk("dbz_idle",       int'(div_if.div_by_zero), 0);
      end
    end
  end

  initial begin
    int e;
    int busy_cnt;
    div_if.start    = 1'b0;
    div_if.dividend = '0;
    div_if.divisor  = '0;
    step();
    step();
    chk_zero_outputs("reset");
    rst = 1'b0;
    free_edge = edge_n + 1;

    // 35/7 with busy width
    launch(8'd35, 4'd7, e);
    busy_cnt = 0;
    while (edge_n <= e + DW) begin
      if (div_if.busy) busy_cnt++;
      step();
    end
    chk("busy_cycles_35_7", busy_cnt, DW);
    wait_free(2);

    // back-to-back chain with no IDLE gap
    launch(8'd200, 4'd9, e);
    wait_free(0);
    launch(8'd7, 4'd9, e);
    wait_free(0);
    launch(8'd225, 4'd15, e);
    wait_free(1);

    // start pulsed mid-RUN with different operands must be ignored
    launch(8'd35, 4'd7, e);
    while (edge_n < e + 2) step();
    div_if.start    = 1'b1;
    div_if.dividend = 8'd99;
    div_if.divisor  = 4'd3;
    step();
    div_if.start    = 1'b0;
    wait_free(2);

    // reset during the 4th RUN cycle aborts the division
    launch(8'd50, 4'd6, e);
    while (edge_n < e + 3) step();
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk_zero_outputs("reset_midrun");
    step();
    rst = 1'b0;
    launch(8'd81, 4'd9, e);
    wait_free(2);

    launch(8'd100, 4'd0, e);
    wait_free(1);

    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] a;
      logic [SW-1:0] b;
      a = DW'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom_range(1, 15));
      launch(a, b, e);
      wait_free($urandom_range(0, 2));
    end

    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 50) begin
        step();
        guard++;
      end
    end
    chk("drain_pending", sb.size(), 0);
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
